instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Single-stage instruction fetch. It holds a word-addressed PC that drives
// the instruction ROM directly. The ROM word that comes back in the same
// cycle is registered toward decode. Unconditional B instructions are
// optionally resolved here with zero bubbles. A dedicated halt word parks
// the unit in HALT until a redirect or a reset arrives.
//
// Ports
//   clock          in   1   single clock, rising edge
//   reset_n        in   1   synchronous, active-low reset
//   rom_addr       out  16  word address to ROM (the PC register itself)
//   rom_data       in   32  ROM word for rom_addr, same cycle
//   stall          in   1   downstream not ready: freeze all state
//   redirect_valid in   1   later stage requests a PC change
//   redirect_addr  in   16  target word address for the redirect
//   if_instr       out  32  registered instruction to decode
//   if_pc          out  16  registered word address of if_instr
//   if_valid       out  1   if_instr/if_pc carry a real instruction
//   halted         out  1   FSM is in HALT (also the FSM state observation)
//   fetch_cnt      out  16  instructions delivered, saturating at 16'hFFFF
//
// Flow control: this is not a valid/ready pair. if_valid qualifies
// if_instr/if_pc. While stall is high, every register holds its value, so
// the same instruction stays presented. A redirect beats stall, and a
// reset beats everything.
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter bit          EARLY_BRANCH = 1'b1,
    parameter logic [31:0] HALT_WORD    = 32'hD60003E0,
    parameter bit          HALT_EN      = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic [31:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [5:0] OPC_B = 6'b000101;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic        is_halt_word;
    logic        is_branch;

    assign is_halt_word = HALT_EN && (rom_data == HALT_WORD);
    assign is_branch    = EARLY_BRANCH && (rom_data[31:26] == OPC_B);

    // Next-state and datapath. Priority is redirect, then stall, then the
    // normal per-state action. Reset is handled in the register process.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (redirect_valid) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall) begin
            // Hold everything.
        end else begin
            case (state_q)
                RUN: begin
                    instr_d = rom_data;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    // The halt check comes first. If the halt word also
                    // decodes as a B, it still halts and does not branch.
                    if (is_halt_word) begin
                        state_d = HALT;
                    end else if (is_branch) begin
                        pc_d = pc_q + rom_data[15:0];
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            ifpc_q  <= 16'h0;
            valid_q <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr  = pc_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign if_valid  = valid_q;
    assign halted    = (state_q == HALT);
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. The ROM is a bench-side array read
// combinationally at rom_addr. A table of {inputs, expected outputs}
// records is applied one clock per record. Hand-written sequences then
// cover counter saturation and PC wrap-around.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    always #5 clock = ~clock;

    logic [31:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    instruction_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        rv;
        logic [15:0] ra;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [31:0] e_instr;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] W0   = 32'h910193E4;
    localparam logic [31:0] BM7  = 32'h17FFFFF9;  // B -7
    localparam logic [31:0] BP16 = 32'h14000010;  // B +16
    localparam logic [31:0] HLT  = 32'hD60003E0;

    function automatic logic [31:0] dflt(input logic [15:0] a);
        return {16'h8B00, a};  // opcode 100010: neither B nor halt
    endfunction

    task automatic add(input logic rst_n, input logic stl, input logic rv,
                       input logic [15:0] ra, input logic [15:0] e_addr,
                       input logic e_valid, input logic [15:0] e_pc,
                       input logic [31:0] e_instr, input logic e_halt,
                       input logic [15:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.stl = stl; v.rv = rv; v.ra = ra;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_halt = e_halt; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst_n, input logic stl, input logic rv,
                         input logic [15:0] ra);
        reset_n        = rst_n;
        stall          = stl;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(posedge clock);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [15:0] e_addr,
                         input logic e_valid, input logic [15:0] e_pc,
                         input logic [31:0] e_instr, input logic e_halt,
                         input logic [15:0] e_cnt);
        n_vec++;
        if (rom_addr !== e_addr || if_valid !== e_valid || if_pc !== e_pc ||
            if_instr !== e_instr || halted !== e_halt || fetch_cnt !== e_cnt) begin
            n_bad++;
            $display("FAIL %s: got addr=%h valid=%b pc=%h instr=%h halted=%b cnt=%h, want addr=%h valid=%b pc=%h instr=%h halted=%b cnt=%h",
                     name, rom_addr, if_valid, if_pc, if_instr, halted, fetch_cnt,
                     e_addr, e_valid, e_pc, e_instr, e_halt, e_cnt);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0;

        for (int i = 0; i < 65536; i++) rom[i] = dflt(i[15:0]);
        rom[16'h0000] = W0;
        rom[16'h0009] = BM7;
        rom[16'h000A] = HLT;
        rom[16'h0020] = BP16;

        //   rst stl rv ra       addr     v  pc       instr        h  cnt
        add(0, 0, 0, 16'h0,    16'h0000, 0, 16'h0000, 32'h0,       0, 16'd0);
        add(0, 1, 1, 16'h0055, 16'h0000, 0, 16'h0000, 32'h0,       0, 16'd0);
        add(1, 0, 0, 16'h0,    16'h0001, 1, 16'h0000, W0,          0, 16'd1);
        add(1, 0, 0, 16'h0,    16'h0002, 1, 16'h0001, dflt(16'h1), 0, 16'd2);
        // three-cycle stall mid-stream
        add(1, 1, 0, 16'h0,    16'h0002, 1, 16'h0001, dflt(16'h1), 0, 16'd2);
        add(1, 1, 0, 16'h0,    16'h0002, 1, 16'h0001, dflt(16'h1), 0, 16'd2);
        add(1, 1, 0, 16'h0,    16'h0002, 1, 16'h0001, dflt(16'h1), 0, 16'd2);
        add(1, 0, 0, 16'h0,    16'h0003, 1, 16'h0002, dflt(16'h2), 0, 16'd3);
        // redirect wins over stall
        add(1, 1, 1, 16'h0009, 16'h0009, 0, 16'h0002, dflt(16'h2), 0, 16'd3);
        // B -7 at 0x0009 goes to 0x0002 with no bubble
        add(1, 0, 0, 16'h0,    16'h0002, 1, 16'h0009, BM7,         0, 16'd4);
        add(1, 0, 0, 16'h0,    16'h0003, 1, 16'h0002, dflt(16'h2), 0, 16'd5);
        // B +16 at 0x0020 goes to 0x0030
        add(1, 0, 1, 16'h0020, 16'h0020, 0, 16'h0002, dflt(16'h2), 0, 16'd5);
        add(1, 0, 0, 16'h0,    16'h0030, 1, 16'h0020, BP16,        0, 16'd6);
        add(1, 0, 0, 16'h0,    16'h0031, 1, 16'h0030, dflt(16'h30), 0, 16'd7);
        // redirect to the current PC: one bubble, then refetch
        add(1, 0, 1, 16'h0031, 16'h0031, 0, 16'h0030, dflt(16'h30), 0, 16'd7);
        add(1, 0, 0, 16'h0,    16'h0032, 1, 16'h0031, dflt(16'h31), 0, 16'd8);
        // halt word at 0x000A
        add(1, 0, 1, 16'h000A, 16'h000A, 0, 16'h0031, dflt(16'h31), 0, 16'd8);
        add(1, 0, 0, 16'h0,    16'h000A, 1, 16'h000A, HLT,         1, 16'd9);
        add(1, 0, 0, 16'h0,    16'h000A, 0, 16'h000A, HLT,         1, 16'd9);
        add(1, 0, 0, 16'h0,    16'h000A, 0, 16'h000A, HLT,         1, 16'd9);
        add(1, 1, 0, 16'h0,    16'h000A, 0, 16'h000A, HLT,         1, 16'd9);
        // redirect leaves HALT
        add(1, 0, 1, 16'h0000, 16'h0000, 0, 16'h000A, HLT,         0, 16'd9);
        add(1, 0, 0, 16'h0,    16'h0001, 1, 16'h0000, W0,          0, 16'd10);
        // halt again, then reset mid-HALT with stall and redirect also high
        add(1, 0, 1, 16'h000A, 16'h000A, 0, 16'h0000, W0,          0, 16'd10);
        add(1, 0, 0, 16'h0,    16'h000A, 1, 16'h000A, HLT,         1, 16'd11);
        add(0, 1, 1, 16'h0055, 16'h0000, 0, 16'h0000, 32'h0,       0, 16'd0);
        add(1, 0, 0, 16'h0,    16'h0001, 1, 16'h0000, W0,          0, 16'd1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst_n, vecs[k].stl, vecs[k].rv, vecs[k].ra);
            check($sformatf("vec%0d", k), vecs[k].e_addr, vecs[k].e_valid,
                  vecs[k].e_pc, vecs[k].e_instr, vecs[k].e_halt, vecs[k].e_cnt);
        end

        // ---------- saturation and wrap: straight-line code over all 64K ----------
        for (int i = 0; i < 65536; i++) rom[i] = dflt(i[15:0]);
        drive(0, 0, 0, 16'h0);
        check("sat_reset", 16'h0000, 0, 16'h0000, 32'h0, 0, 16'd0);
        for (int i = 0; i < 65535; i++) drive(1, 0, 0, 16'h0);
        check("at_ffff", 16'hFFFF, 1, 16'hFFFE, dflt(16'hFFFE), 0, 16'hFFFF);
        drive(1, 0, 0, 16'h0);
        check("wrap", 16'h0000, 1, 16'hFFFF, dflt(16'hFFFF), 0, 16'hFFFF);
        drive(1, 0, 0, 16'h0);
        check("sat_hold", 16'h0001, 1, 16'h0000, dflt(16'h0000), 0, 16'hFFFF);

        // ---------- a stall after saturation still holds everything ----------
        drive(1, 1, 0, 16'h0);
        check("sat_stall", 16'h0001, 1, 16'h0000, dflt(16'h0000), 0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
